or1k_dpram_ctrl: RTL and testbench

- Two-requester controller for one single-clock simple dual-port RAM (one read port, one write port, 1-cycle registered read).
- Shares the write port and the read port independently between requester 0 and requester 1, each with round-robin arbitration.
- After reset, a hardware clear sequencer zero-fills the RAM, because init-time clearing is simulation-only.
- Sits between two pipeline clients (e.g. fetch/LSU side structures) and the RAM instance. The RAM instance is built with its same-address read/write bypass enabled.

---
 rtl/or1k_dpram_ctrl_pkg.sv | 18 +
 rtl/or1k_rr_arb2.sv | 36 +++
 rtl/or1k_dpram_ctrl.sv | 125 ++++++++++++
 tb/tb_or1k_dpram_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_dpram_ctrl_pkg.sv
// Shared types for the two-requester dual-port RAM controller.
package or1k_dpram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NREQ = 2;

    typedef logic [$clog2(NREQ)-1:0] req_id_t;

    // Index of the granted requester; only meaningful for a one-hot grant.
    function automatic req_id_t onehot_to_id(input logic [NREQ-1:0] oh);
        return req_id_t'(oh[1]);
    endfunction

endpackage

// File: rtl/or1k_rr_arb2.sv
// Two-way round-robin arbiter: on conflict the requester not granted last wins.
module or1k_rr_arb2
    import or1k_dpram_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    // last_q = 1 means requester 1 holds the most recent grant.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/or1k_dpram_ctrl.sv
// Shares the write and read ports of a simple dual-port RAM between two
// requesters, with a post-reset zero-fill sequence.
module or1k_dpram_ctrl
    import or1k_dpram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              wr_valid,
    output logic [1:0]              wr_ready,
    input  logic [2*ADDR_WIDTH-1:0] wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    input  logic [1:0]              rd_valid,
    output logic [1:0]              rd_ready,
    input  logic [2*ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]              rd_rsp_valid,
    output logic [DATA_WIDTH-1:0]   rd_rsp_data,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    output logic                    ram_re,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    output state_e                  dbg_state
);

    // Handshake: a request is issued in the cycle where valid and ready are
    // both high; ready depends only on valid, address-free arbitration state
    // and the FSM, never on RAM data. Read data returns exactly one cycle
    // later with no backpressure.

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;

    logic [1:0]              wr_req, rd_req;
    logic [1:0]              wr_gnt, rd_gnt;
    req_id_t                 wr_id, rd_id;

    // Arbiters see no requests while clearing, so their pointers stay put.
    assign wr_req = (state_q == RUN) ? wr_valid : 2'b00;
    assign rd_req = (state_q == RUN) ? rd_valid : 2'b00;

    or1k_rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    or1k_rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    assign wr_id = onehot_to_id(wr_gnt);
    assign rd_id = onehot_to_id(rd_gnt);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = 2'b00;
        wr_ready    = 2'b00;
        rd_ready    = 2'b00;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = wr_addr[wr_id*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din     = wr_data[wr_id*DATA_WIDTH +: DATA_WIDTH];
        ram_raddr   = rd_addr[rd_id*ADDR_WIDTH +: ADDR_WIDTH];
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_din   = '0;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                wr_ready    = wr_gnt;
                ram_we      = |wr_gnt;
                rd_ready    = rd_gnt;
                ram_re      = |rd_gnt;
                rsp_valid_d = rd_gnt;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (CLEAR_ON_RESET) begin
                state_q <= CLEAR;
            end else begin
                state_q <= RUN;
            end
            cnt_q       <= '0;
            init_done_q <= ~CLEAR_ON_RESET;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = ram_dout;
    assign init_done    = init_done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_or1k_dpram_ctrl.sv
// Bench for or1k_dpram_ctrl: two instances (with and without clear), each
// attached to a behavioural bypassing RAM, checked against a reference model.
module tb_or1k_dpram_ctrl;
    import or1k_dpram_ctrl_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scramble = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT with clear ----------------
    logic [1:0]      wr_valid = '0, wr_ready, rd_valid = '0, rd_ready, rd_rsp_valid;
    logic [2*AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic [DW-1:0]   rd_rsp_data, ram_din, ram_dout;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic            ram_we, ram_re, init_done;
    state_e          dbg_state;

    or1k_dpram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .init_done(init_done),
        .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout),
        .dbg_state(dbg_state)
    );

    // Behavioural RAM: registered read, same-address write bypass.
    logic [DW-1:0] ram_a [DEPTH];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) ram_a[i] <= $urandom;
        end else begin
            if (ram_re) ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : ram_a[ram_raddr];
            if (ram_we) ram_a[ram_waddr] <= ram_din;
        end
    end

    // ---------------- DUT without clear ----------------
    logic [1:0]      n_wr_valid = '0, n_wr_ready, n_rd_valid = '0, n_rd_ready, n_rd_rsp_valid;
    logic [2*AW-1:0] n_wr_addr = '0, n_rd_addr = '0;
    logic [2*DW-1:0] n_wr_data = '0;
    logic [DW-1:0]   n_rd_rsp_data, n_ram_din, n_ram_dout;
    logic [AW-1:0]   n_ram_waddr, n_ram_raddr;
    logic            n_ram_we, n_ram_re, n_init_done;
    state_e          n_dbg_state;

    or1k_dpram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .wr_valid(n_wr_valid), .wr_ready(n_wr_ready), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
        .rd_valid(n_rd_valid), .rd_ready(n_rd_ready), .rd_addr(n_rd_addr),
        .rd_rsp_valid(n_rd_rsp_valid), .rd_rsp_data(n_rd_rsp_data), .init_done(n_init_done),
        .ram_waddr(n_ram_waddr), .ram_we(n_ram_we), .ram_din(n_ram_din),
        .ram_raddr(n_ram_raddr), .ram_re(n_ram_re), .ram_dout(n_ram_dout),
        .dbg_state(n_dbg_state)
    );

    logic [DW-1:0] n_ram_a [DEPTH];
    always @(posedge clk) begin
        if (n_ram_re) n_ram_dout <= (n_ram_we && n_ram_waddr == n_ram_raddr) ? n_ram_din : n_ram_a[n_ram_raddr];
        if (n_ram_we) n_ram_a[n_ram_waddr] <= n_ram_din;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_mem [DEPTH];
    logic          wr_last, rd_last;       // 1 = requester 1 won most recently
    logic [1:0]    pend_v;                 // response expected in the next cycle
    logic [DW-1:0] exp_q [$];              // its data

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        wr_last = 1'b1;
        rd_last = 1'b1;
        pend_v  = 2'b00;
        exp_q.delete();
    endtask

    // Advance the model by one RUN cycle using the currently driven inputs.
    task automatic model_step();
        logic [1:0]    wg, rg;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        wg = rr_pick(wr_valid, wr_last);
        rg = rr_pick(rd_valid, rd_last);
        wa = wg[1] ? wr_addr[AW +: AW] : wr_addr[0 +: AW];
        wd = wg[1] ? wr_data[DW +: DW] : wr_data[0 +: DW];
        ra = rg[1] ? rd_addr[AW +: AW] : rd_addr[0 +: AW];
        exp_q.delete();
        pend_v = rg;
        if (rg != 2'b00) exp_q.push_back((wg != 2'b00 && wa == ra) ? wd : exp_mem[ra]);
        if (wg != 2'b00) begin
            exp_mem[wa] = wd;
            wr_last     = wg[1];
        end
        if (rg != 2'b00) rd_last = rg[1];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        tick();
        scramble = 1'b0;
        tick();
        checks++;
        if (init_done !== 1'b0 || rd_rsp_valid !== 2'b00 || dbg_state !== CLEAR) begin
            failures++;
            $display("FAIL reset_state init_done=%b rsp_valid=%b state=%0d, want 0 00 CLEAR", init_done, rd_rsp_valid, dbg_state);
        end
        rst = 1'b1;
        wr_valid = 2'b11;
        rd_valid = 2'b11;
        wr_addr  = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
        wr_data  = {$urandom, $urandom};
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_waddr !== AW'(i) || ram_din !== '0 || ram_re !== 1'b0) begin
                failures++;
                $display("FAIL clear_write i=%0d we=%b waddr=%0d din=%h re=%b, want 1 %0d 0 0", i, ram_we, ram_waddr, ram_din, ram_re, i);
            end
            checks++;
            if (wr_ready !== 2'b00 || rd_ready !== 2'b00 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL clear_ready i=%0d wr_ready=%b rd_ready=%b init_done=%b, want 00 00 0", i, wr_ready, rd_ready, init_done);
            end
            if (i == DEPTH - 1) begin
                wr_valid = 2'b00;
                rd_valid = 2'b00;
            end
            tick();
        end
        #1;
        checks++;
        if (init_done !== 1'b1 || ram_we !== 1'b0 || dbg_state !== RUN) begin
            failures++;
            $display("FAIL clear_done init_done=%b we=%b state=%0d, want 1 0 RUN", init_done, ram_we, dbg_state);
        end
        model_reset();
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a <= DEPTH; a++) begin
            rd_valid = (a < DEPTH) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd_addr  = {AW'(a), AW'(a)};
            #1;
            checks++;
            if (rd_ready !== rr_pick(rd_valid, rd_last)) begin
                failures++;
                $display("FAIL clear_rd_ready a=%0d got=%b want=%b", a, rd_ready, rr_pick(rd_valid, rd_last));
            end
            if (a > 0) begin
                checks++;
                if (rd_rsp_valid !== pend_v || rd_rsp_data !== '0) begin
                    failures++;
                    $display("FAIL clear_rd_data a=%0d valid=%b data=%h, want %b 0", a - 1, rd_rsp_valid, rd_rsp_data, pend_v);
                end
            end
            model_step();
            tick();
        end
    endtask

    task automatic test_wr_alternate();
        wr_valid = 2'b11;
        wr_addr  = {AW'(5), AW'(3)};
        wr_data  = {32'h0000_00B0, 32'h0000_00A0};
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (wr_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || ram_we !== 1'b1) begin
                failures++;
                $display("FAIL wr_alt k=%0d wr_ready=%b we=%b, want %b 1", k, wr_ready, ram_we, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            checks++;
            if (ram_waddr !== ((k % 2 == 0) ? AW'(3) : AW'(5)) || ram_din !== ((k % 2 == 0) ? 32'hA0 : 32'hB0)) begin
                failures++;
                $display("FAIL wr_alt_port k=%0d waddr=%0d din=%h", k, ram_waddr, ram_din);
            end
            model_step();
            tick();
        end
        wr_valid = 2'b00;
    endtask

    task automatic test_rd_b2b();
        logic [AW-1:0] seq [4];
        seq[0] = AW'(5); seq[1] = AW'(3); seq[2] = AW'(5); seq[3] = AW'(3);
        for (int k = 0; k <= 4; k++) begin
            rd_valid = (k < 4) ? 2'b10 : 2'b00;
            rd_addr  = {(k < 4) ? seq[k] : AW'(0), AW'(0)};
            #1;
            if (k < 4) begin
                checks++;
                if (rd_ready !== 2'b10 || ram_raddr !== seq[k]) begin
                    failures++;
                    $display("FAIL rd_b2b_ready k=%0d rd_ready=%b raddr=%0d, want 10 %0d", k, rd_ready, ram_raddr, seq[k]);
                end
            end
            if (k > 0) begin
                checks++;
                if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== ((seq[k-1] == AW'(5)) ? 32'hB0 : 32'hA0)) begin
                    failures++;
                    $display("FAIL rd_b2b_rsp k=%0d valid=%b data=%h", k - 1, rd_rsp_valid, rd_rsp_data);
                end
            end
            model_step();
            tick();
        end
    endtask

    task automatic test_rd_wr_same_addr();
        wr_valid = 2'b01;
        wr_addr  = {AW'(0), AW'(7)};
        wr_data  = {32'h0, 32'h0000_DEAD};
        rd_valid = 2'b10;
        rd_addr  = {AW'(7), AW'(0)};
        #1;
        checks++;
        if (wr_ready !== 2'b01 || rd_ready !== 2'b10) begin
            failures++;
            $display("FAIL same_addr_ready wr=%b rd=%b, want 01 10", wr_ready, rd_ready);
        end
        model_step();
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        #1;
        checks++;
        if (rd_rsp_valid !== 2'b10 || rd_rsp_data !== 32'h0000_DEAD) begin
            failures++;
            $display("FAIL same_addr_rsp valid=%b data=%h, want 10 0000dead", rd_rsp_valid, rd_rsp_data);
        end
        model_step();
        tick();
    endtask

    task automatic test_random();
        logic [1:0]    wg, rg;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        for (int c = 0; c <= 200; c++) begin
            wr_valid = (c < 200) ? 2'($urandom_range(0, 3)) : 2'b00;
            rd_valid = (c < 200) ? 2'($urandom_range(0, 3)) : 2'b00;
            wr_addr  = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            wr_data  = {$urandom, $urandom};
            rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            #1;
            wg = rr_pick(wr_valid, wr_last);
            rg = rr_pick(rd_valid, rd_last);
            wa = wg[1] ? wr_addr[AW +: AW] : wr_addr[0 +: AW];
            wd = wg[1] ? wr_data[DW +: DW] : wr_data[0 +: DW];
            ra = rg[1] ? rd_addr[AW +: AW] : rd_addr[0 +: AW];
            checks++;
            if (wr_ready !== wg || rd_ready !== rg || ram_we !== (|wg) || ram_re !== (|rg)) begin
                failures++;
                $display("FAIL rand_grant c=%0d wr_ready=%b rd_ready=%b we=%b re=%b, want %b %b", c, wr_ready, rd_ready, ram_we, ram_re, wg, rg);
            end
            checks++;
            if ((wg != 2'b00 && (ram_waddr !== wa || ram_din !== wd)) || (rg != 2'b00 && ram_raddr !== ra)) begin
                failures++;
                $display("FAIL rand_port c=%0d waddr=%0d din=%h raddr=%0d, want %0d %h %0d", c, ram_waddr, ram_din, ram_raddr, wa, wd, ra);
            end
            checks++;
            if (rd_rsp_valid !== pend_v || (pend_v != 2'b00 && exp_q.size() > 0 && rd_rsp_data !== exp_q[0])) begin
                failures++;
                $display("FAIL rand_rsp c=%0d valid=%b data=%h, want %b %h", c, rd_rsp_valid, rd_rsp_data, pend_v, (exp_q.size() > 0) ? exp_q[0] : '0);
            end
            model_step();
            tick();
        end
    endtask

    task automatic test_reset_mid();
        // A read accepted in the reset cycle must not produce a response.
        rd_valid = 2'b01;
        rd_addr  = {AW'(0), AW'(3)};
        rst = 1'b0;
        tick();
        rd_valid = 2'b00;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_rsp_valid !== 2'b00 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_rsp valid=%b init_done=%b, want 00 0", rd_rsp_valid, init_done);
        end
        for (int i = 0; i < 9; i++) tick();
        #1;
        checks++;
        if (ram_waddr !== AW'(9) || ram_we !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_cnt waddr=%0d we=%b, want 9 1", ram_waddr, ram_we);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (ram_we !== 1'b1 || ram_waddr !== AW'(i) || init_done !== 1'b0 || rd_ready !== 2'b00) begin
                failures++;
                $display("FAIL reclear i=%0d we=%b waddr=%0d init_done=%b rd_ready=%b", i, ram_we, ram_waddr, init_done, rd_ready);
            end
            tick();
        end
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL reclear_done init_done=%b, want 1", init_done);
        end
        model_reset();
    endtask

    task automatic test_no_clear();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (n_init_done !== 1'b1 || n_dbg_state !== RUN) begin
            failures++;
            $display("FAIL noclear_reset init_done=%b state=%0d, want 1 RUN", n_init_done, n_dbg_state);
        end
        rst = 1'b1;
        n_wr_valid = 2'b11;
        n_wr_addr  = {AW'(3), AW'(2)};
        n_wr_data  = {32'h1111_D1D1, 32'h0000_D0D0};
        n_rd_valid = 2'b11;
        n_rd_addr  = {AW'(3), AW'(2)};
        #1;
        checks++;
        if (n_wr_ready !== 2'b01 || n_rd_ready !== 2'b01) begin
            failures++;
            $display("FAIL noclear_first wr=%b rd=%b, want 01 01", n_wr_ready, n_rd_ready);
        end
        tick();
        #1;
        checks++;
        if (n_wr_ready !== 2'b10 || n_rd_ready !== 2'b10 || n_rd_rsp_valid !== 2'b01 || n_rd_rsp_data !== 32'h0000_D0D0) begin
            failures++;
            $display("FAIL noclear_second wr=%b rd=%b rsp=%b data=%h, want 10 10 01 0000d0d0", n_wr_ready, n_rd_ready, n_rd_rsp_valid, n_rd_rsp_data);
        end
        tick();
        n_wr_valid = 2'b00;
        n_rd_valid = 2'b00;
        #1;
        checks++;
        if (n_rd_rsp_valid !== 2'b10 || n_rd_rsp_data !== 32'h1111_D1D1) begin
            failures++;
            $display("FAIL noclear_third rsp=%b data=%h, want 10 1111d1d1", n_rd_rsp_valid, n_rd_rsp_data);
        end
        tick();
        #1;
        checks++;
        if (n_rd_rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL noclear_idle rsp=%b, want 00", n_rd_rsp_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clear_reads();
        test_wr_alternate();
        test_rd_b2b();
        test_rd_wr_same_addr();
        test_random();
        test_reset_mid();
        test_no_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
